// File: rtl/cam_capture_rgb444.sv
// ----------------------------------------------------------------------------
// cam_capture_rgb444
//
// Camera capture stage feeding the frame buffer that the VGA driver scans out.
// Samples an OV7670-style parallel camera bus in the system clock domain. Every
// pair of RGB565 bytes is packed into one 12-bit RGB444 pixel. Each pixel is
// written to the frame buffer at the linear address row*IMG_W + col.
//
// Build option:
//   CAM_TEST_PATTERN_EN - when defined, pixel data is replaced by 8 vertical
//                         colour bars, driven by a per-line column counter.
//                         Timing, addressing, frame_done and overflow are
//                         unchanged, and cam_data_i is ignored.
//
// Parameters:
//   DW     pixel width in the frame buffer (RGB444, 12)
//   AW     frame-buffer address width
//   IMG_W  pixels per captured line
//   IMG_H  lines per captured frame
//
// Ports:
//   clk_i          system clock, at least 3x the camera pixel clock
//   rst_i          synchronous, active-high reset
//   pclk_i         camera pixel clock, sampled as data
//   cam_vsync_i    camera frame sync, high between frames
//   cam_href_i     camera line valid
//   cam_data_i     camera byte
//   px_data_o      packed pixel for the buffer
//   px_addr_o      buffer write address, holds its value between writes
//   px_wr_o        write strobe, one clk_i per pixel
//   frame_done_o   one-cycle pulse when the frame ends (vsync rise)
//   overflow_o     sticky: more than IMG_W*IMG_H pixels arrived this frame
// ----------------------------------------------------------------------------
module cam_capture_rgb444 #(
    parameter int DW    = 12,
    parameter int AW    = 15,
    parameter int IMG_W = 160,
    parameter int IMG_H = 120
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          pclk_i,
    input  logic          cam_vsync_i,
    input  logic          cam_href_i,
    input  logic [7:0]    cam_data_i,
    output logic [DW-1:0] px_data_o,
    output logic [AW-1:0] px_addr_o,
    output logic          px_wr_o,
    output logic          frame_done_o,
    output logic          overflow_o
);

    localparam logic [AW-1:0] LAST_ADDR = AW'(IMG_W * IMG_H - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_BYTE1 = 2'd1,
        S_BYTE2 = 2'd2
    } state_t;

    // ------------------------------------------------------------------------
    // Input synchronisers. Bit 0 is s1 and bit 1 is s2. The extra stage on
    // pclk and vsync is the delayed copy used for edge detection.
    // ------------------------------------------------------------------------
    logic [2:0] pclk_sync_q;
    logic [2:0] vs_sync_q;
    logic [1:0] href_sync_q;
    logic [7:0] data_s1_q;
    logic [7:0] data_s2_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            pclk_sync_q <= '0;
            vs_sync_q   <= '0;
            href_sync_q <= '0;
            data_s1_q   <= '0;
            data_s2_q   <= '0;
        end else begin
            pclk_sync_q <= {pclk_sync_q[1:0], pclk_i};
            vs_sync_q   <= {vs_sync_q[1:0], cam_vsync_i};
            href_sync_q <= {href_sync_q[0], cam_href_i};
            data_s1_q   <= cam_data_i;
            data_s2_q   <= data_s1_q;
        end
    end

    logic pclk_rise;
    logic vs_rise;
    logic vs_fall;
    logic href;

    assign pclk_rise = pclk_sync_q[1] & ~pclk_sync_q[2];
    assign vs_rise   = vs_sync_q[1]   & ~vs_sync_q[2];
    assign vs_fall   = ~vs_sync_q[1]  &  vs_sync_q[2];
    assign href      = href_sync_q[1];

    // ------------------------------------------------------------------------
    // Capture state and registered outputs
    // ------------------------------------------------------------------------
    state_t          state_q;
    logic [6:0]      hi_q;          // first byte, keeping only the bits the pack uses
    logic [AW-1:0]   next_addr_q;   // address the next accepted pixel goes to
    logic            full_q;        // LAST_ADDR already written this frame
    logic [DW-1:0]   px_data_q;
    logic [AW-1:0]   px_addr_q;
    logic            px_wr_q;
    logic            frame_done_q;
    logic            overflow_q;

    logic [6:0]      hi_d;
    logic [11:0]     pix_d;
    logic            wr_req;

    // hi byte = RRRRRGGG: keep R[4:1] and G[5:3]
    assign hi_d   = {data_s2_q[7:4], data_s2_q[2:0]};
    // Second byte completes a pixel. The monitor of HREF in BYTE2 is the same
    // s2 sample, so a byte seen with HREF low never turns into a write.
    assign wr_req = (state_q == S_BYTE2) && href && pclk_rise;

`ifdef CAM_TEST_PATTERN_EN
    // ------------------------------------------------------------------------
    // Colour-bar generator. The column counts completed pixels on the current
    // line and clears whenever HREF is low. It saturates instead of wrapping,
    // so over-long lines cannot alias back onto the first bars.
    // ------------------------------------------------------------------------
    localparam int CW    = $clog2(IMG_W) + 1;
    localparam int BAR_W = (IMG_W / 8 > 0) ? IMG_W / 8 : 1;

    logic [CW-1:0] col_q;
    logic [CW-1:0] col_d;
    logic [CW-1:0] bar_idx;

    always_comb begin
        col_d = col_q;
        if (state_q == S_IDLE || !href) begin
            col_d = '0;
        end else if (wr_req && (col_q != '1)) begin
            col_d = col_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            col_q <= '0;
        end else begin
            col_q <= col_d;
        end
    end

    assign bar_idx = col_q / CW'(BAR_W);
    assign pix_d   = {{4{bar_idx[2]}}, {4{bar_idx[1]}}, {4{bar_idx[0]}}};

    // Camera byte content is not needed while the pattern is active.
    logic unused_pattern_bits;
    assign unused_pattern_bits = ^{hi_q, data_s2_q[3], bar_idx[CW-1:3]};
`else
    // R[4:1], G[5:2], B[4:1]. G[2] is bit 7 of the second byte.
    assign pix_d = {hi_q, data_s2_q[7], data_s2_q[4:1]};
`endif

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q      <= S_IDLE;
            hi_q         <= '0;
            next_addr_q  <= '0;
            full_q       <= 1'b0;
            px_data_q    <= '0;
            px_addr_q    <= '0;
            px_wr_q      <= 1'b0;
            frame_done_q <= 1'b0;
            overflow_q   <= 1'b0;
        end else begin
            px_wr_q      <= 1'b0;
            frame_done_q <= 1'b0;

            case (state_q)
                // A vsync rise here is ignored. Capture starts only at the
                // start of a frame, so a partial frame is never resumed.
                S_IDLE: begin
                    if (vs_fall) begin
                        next_addr_q <= '0;
                        px_addr_q   <= '0;
                        full_q      <= 1'b0;
                        overflow_q  <= 1'b0;
                        state_q     <= S_BYTE1;
                    end
                end

                S_BYTE1: begin
                    if (vs_rise) begin
                        frame_done_q <= 1'b1;
                        state_q      <= S_IDLE;
                    end else if (pclk_rise && href) begin
                        hi_q    <= hi_d;
                        state_q <= S_BYTE2;
                    end
                end

                S_BYTE2: begin
                    // A completing pixel is written even if vsync rises in the
                    // same cycle. In that case px_wr and frame_done are both
                    // high together.
                    if (wr_req) begin
                        if (full_q) begin
                            overflow_q <= 1'b1;
                        end else begin
                            px_wr_q   <= 1'b1;
                            px_data_q <= DW'(pix_d);
                            px_addr_q <= next_addr_q;
                            if (next_addr_q == LAST_ADDR) begin
                                full_q <= 1'b1;
                            end else begin
                                next_addr_q <= next_addr_q + 1'b1;
                            end
                        end
                    end

                    if (vs_rise) begin
                        frame_done_q <= 1'b1;
                        state_q      <= S_IDLE;
                    end else if (!href || pclk_rise) begin
                        // Either the pair completed or HREF dropped mid-pair.
                        // A dropped partial pixel is simply discarded.
                        state_q <= S_BYTE1;
                    end
                end

                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign px_data_o    = px_data_q;
    assign px_addr_o    = px_addr_q;
    assign px_wr_o      = px_wr_q;
    assign frame_done_o = frame_done_q;
    assign overflow_o   = overflow_q;

endmodule
